data_mem_resp: RTL and testbench

Wait-stated data-memory responder for the ARM core's load/store path. It accepts a single outstanding word request from the CPU (or a future multi-cycle datapath) over a req/ready handshake, inserts a programmable number of wait states, then performs the access and returns a one-cycle completion with read data or an error flag. It replaces the zero-latency data memory so that stall logic in the core can be developed and verified against realistic memory timing.

---
 rtl/data_mem_pkg.sv | 25 ++
 rtl/data_mem_array.sv | 36 +++
 rtl/data_mem_resp.sv | 125 ++++++++++++
 tb/tb_data_mem_resp.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared types and constants for the wait-stated data-memory responder.
package data_mem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned OFFS_W = 2;
  localparam int unsigned IDX_W  = WORD_W - OFFS_W;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  // Source of the rdata output for the most recent response.
  typedef enum logic [1:0] {RdMem, RdEcho, RdZero} rsel_e;

  typedef enum logic [1:0] {FaultNone, FaultAlign, FaultRange} fault_e;

  // Range check uses the full word index, before truncation to the array width.
  function automatic fault_e fault_code(input logic [WORD_W-1:0] a, input int unsigned depth);
    logic [IDX_W-1:0] idx;
    idx = a[WORD_W-1:OFFS_W];
    if (a[OFFS_W-1:0] != '0) return FaultAlign;
    if (idx >= IDX_W'(depth)) return FaultRange;
    return FaultNone;
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word storage with asynchronous clear, one synchronous write and one synchronous read port.
module data_mem_array
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/data_mem_resp.sv
// Single-outstanding data-memory responder: accepts a word request, waits WAIT_CYCLES,
// then performs the access and pulses ready for one cycle with rdata/err.
module data_mem_resp
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic              ready,
  output logic [WORD_W-1:0] rdata,
  output logic              err,
  output logic              busy
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic              we_q;
  logic [WORD_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] echo_q;
  rsel_e             sel_q;
  logic              err_q;

  logic              access;
  logic              acc_we;
  logic [WORD_W-1:0] acc_addr;
  logic [WORD_W-1:0] acc_wdata;
  logic              acc_ok;
  logic [WORD_W-1:0] mem_rdata;

  // With zero wait states the access happens on the accepting edge, straight from the inputs.
  always_comb begin
    access    = 1'b0;
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (state == StIdle) begin
      access    = req && (WAIT_CYCLES == 0);
      acc_we    = we;
      acc_addr  = addr;
      acc_wdata = wdata;
    end else if (state == StWait) begin
      access = (cnt == CNT_W'(1));
    end
    acc_ok = (fault_code(acc_addr, DEPTH_WORDS) == FaultNone);
  end

  data_mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (access && acc_we && acc_ok),
    .waddr(acc_addr[AW+OFFS_W-1:OFFS_W]),
    .wdata(acc_wdata),
    .re   (access && !acc_we && acc_ok),
    .raddr(acc_addr[AW+OFFS_W-1:OFFS_W]),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= StIdle;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      echo_q  <= '0;
      sel_q   <= RdZero;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (req) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            cnt     <= CNT_W'(WAIT_CYCLES);
            state   <= (WAIT_CYCLES == 0) ? StResp : StWait;
          end
        end
        StWait: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= StResp;
        end
        StResp:  state <= StIdle;
        default: state <= StIdle;
      endcase
      if (access) begin
        err_q <= !acc_ok;
        if (!acc_ok) begin
          sel_q <= RdZero;
        end else if (acc_we) begin
          sel_q  <= RdEcho;
          echo_q <= acc_wdata;
        end else begin
          sel_q <= RdMem;
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    unique case (sel_q)
      RdMem:   rdata = mem_rdata;
      RdEcho:  rdata = echo_q;
      default: rdata = '0;
    endcase
  end

  assign ready = (state == StResp);
  assign busy  = (state != StIdle);
  assign err   = err_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
module tb_data_mem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic        ready, err, busy;
  logic [31:0] rdata;
  logic        req0, we0;
  logic [31:0] addr0, wdata0;
  logic        ready0, err0, busy0;
  logic [31:0] rdata0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_mem_resp #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready), .rdata(rdata), .err(err), .busy(busy)
  );

  data_mem_resp #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .ready(ready0), .rdata(rdata0), .err(err0), .busy(busy0)
  );

  // Issues one request on the WAIT_CYCLES=2 instance and waits (bounded) for ready.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic e, output int lat, output int bc);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    lat = 0; bc = 0;
    do begin
      @(negedge clk);
      req = 1'b0;
      lat++;
      if (busy) bc++;
    end while (!ready && lat < 20);
    rd = rdata;
    e  = err;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b want 0", ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    checks++; if (ready0 !== 1'b0 || busy0 !== 1'b0) begin
      failures++; $display("FAIL reset_dut0: ready=%b busy=%b want 0/0", ready0, busy0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_latency();
    logic [31:0] rd; logic e; int lat, bc;
    txn(1'b0, 32'h10, 32'h0, rd, e, lat, bc);
    checks++; if (lat !== 3) begin failures++; $display("FAIL latency: got %0d want 3", lat); end
    checks++; if (bc !== 3) begin failures++; $display("FAIL busy_cycles: got %0d want 3", bc); end
    checks++; if (rd !== 32'h0 || e !== 1'b0) begin
      failures++; $display("FAIL load_0x10: rdata=%h err=%b want 00000000/0", rd, e);
    end
    @(negedge clk);
    checks++; if (ready !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL ready_one_cycle: ready=%b busy=%b want 0/0", ready, busy);
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic e; int lat, bc;
    txn(1'b1, 32'h20, 32'hDEADBEEF, rd, e, lat, bc);
    checks++; if (rd !== 32'hDEADBEEF || e !== 1'b0) begin
      failures++; $display("FAIL store_echo: rdata=%h err=%b want deadbeef/0", rd, e);
    end
    txn(1'b0, 32'h20, 32'h0, rd, e, lat, bc);
    checks++; if (rd !== 32'hDEADBEEF || e !== 1'b0) begin
      failures++; $display("FAIL load_0x20: rdata=%h err=%b want deadbeef/0", rd, e);
    end
  endtask

  task automatic test_fault();
    logic [31:0] rd; logic e; int lat, bc;
    txn(1'b0, 32'h22, 32'h0, rd, e, lat, bc);
    checks++; if (rd !== 32'h0 || e !== 1'b1) begin
      failures++; $display("FAIL misaligned_load: rdata=%h err=%b want 00000000/1", rd, e);
    end
    txn(1'b1, 32'h400, 32'h12345678, rd, e, lat, bc);
    checks++; if (rd !== 32'h0 || e !== 1'b1) begin
      failures++; $display("FAIL range_store: rdata=%h err=%b want 00000000/1", rd, e);
    end
    txn(1'b0, 32'h0, 32'h0, rd, e, lat, bc);
    checks++; if (rd !== 32'h0 || e !== 1'b0) begin
      failures++; $display("FAIL no_corrupt_0x0: rdata=%h err=%b want 00000000/0", rd, e);
    end
    txn(1'b1, 32'h3FC, 32'hA5A5A5A5, rd, e, lat, bc);
    txn(1'b0, 32'h3FC, 32'h0, rd, e, lat, bc);
    checks++; if (rd !== 32'hA5A5A5A5 || e !== 1'b0) begin
      failures++; $display("FAIL last_word: rdata=%h err=%b want a5a5a5a5/0", rd, e);
    end
    txn(1'b0, 32'h3FF, 32'h0, rd, e, lat, bc);
    checks++; if (rd !== 32'h0 || e !== 1'b1) begin
      failures++; $display("FAIL misaligned_0x3ff: rdata=%h err=%b want 00000000/1", rd, e);
    end
  endtask

  task automatic test_ignore_wait();
    logic [31:0] rd; logic e; int lat, bc, n;
    txn(1'b1, 32'h40, 32'h11111111, rd, e, lat, bc);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h40; wdata = 32'h0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!ready) begin
        we = 1'b1; addr = n[0] ? 32'h40 : 32'h41; wdata = 32'hBAD00000 + n;
      end
    end while (!ready && n < 20);
    checks++; if (n !== 3 || rdata !== 32'h11111111 || err !== 1'b0) begin
      failures++; $display("FAIL captured_load: cycles=%0d rdata=%h err=%b want 3/11111111/0", n, rdata, err);
    end
    // req stays high through RESP; must be taken again as a new request from IDLE.
    we = 1'b1; addr = 32'h44; wdata = 32'h22222222;
    @(negedge clk);
    checks++; if (ready !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL idle_after_resp: ready=%b busy=%b want 0/0", ready, busy);
    end
    @(negedge clk);
    req = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL held_req_accepted: busy=%b want 1", busy); end
    n = 1;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n !== 3 || rdata !== 32'h22222222 || err !== 1'b0) begin
      failures++; $display("FAIL second_req: cycles=%0d rdata=%h err=%b want 3/22222222/0", n, rdata, err);
    end
    txn(1'b0, 32'h40, 32'h0, rd, e, lat, bc);
    checks++; if (rd !== 32'h11111111) begin failures++; $display("FAIL wait_no_write: got %h want 11111111", rd); end
    txn(1'b0, 32'h44, 32'h0, rd, e, lat, bc);
    checks++; if (rd !== 32'h22222222) begin failures++; $display("FAIL load_0x44: got %h want 22222222", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic e; int lat, bc, pulses;
    txn(1'b0, 32'h22, 32'h0, rd, e, lat, bc);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h30; wdata = 32'hCAFEF00D;
    @(negedge clk);
    req = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy: got %b want 1", busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || ready !== 1'b0) begin
      failures++; $display("FAIL async_reset: busy=%b ready=%b want 0/0", busy, ready);
    end
    checks++; if (err !== 1'b0 || rdata !== 32'h0) begin
      failures++; $display("FAIL async_reset_out: err=%b rdata=%h want 0/00000000", err, rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL ready_after_abort: got %0d pulses want 0", pulses); end
    txn(1'b0, 32'h30, 32'h0, rd, e, lat, bc);
    checks++; if (rd !== 32'h0 || e !== 1'b0) begin
      failures++; $display("FAIL abort_no_write: rdata=%h err=%b want 00000000/0", rd, e);
    end
  endtask

  task automatic test_back_to_back();
    logic        ow [7];
    logic [31:0] oa [7];
    logic [31:0] od [7];
    logic [31:0] xr [7];
    logic        xe [7];
    ow = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    oa = '{32'h8, 32'hC, 32'h8, 32'hC, 32'h3, 32'h800, 32'h0};
    od = '{32'h01020304, 32'h0A0B0C0D, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h0};
    xr = '{32'h01020304, 32'h0A0B0C0D, 32'h01020304, 32'h0A0B0C0D, 32'h0, 32'h0, 32'h0};
    xe = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    @(negedge clk);
    req0 = 1'b1; we0 = ow[0]; addr0 = oa[0]; wdata0 = od[0];
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checks++; if (ready0 !== 1'b1 || rdata0 !== xr[i] || err0 !== xe[i]) begin
        failures++;
        $display("FAIL b2b_resp[%0d]: ready=%b rdata=%h err=%b want 1/%h/%b",
                 i, ready0, rdata0, err0, xr[i], xe[i]);
      end
      if (i < 6) begin
        we0 = ow[i+1]; addr0 = oa[i+1]; wdata0 = od[i+1];
      end else begin
        req0 = 1'b0;
      end
      @(negedge clk);
      checks++; if (ready0 !== 1'b0) begin failures++; $display("FAIL b2b_gap[%0d]: ready=%b want 0", i, ready0); end
    end
  endtask

  initial begin
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    test_reset();
    test_latency();
    test_store_load();
    test_fault();
    test_ignore_wait();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
